axi_llc_arcane_lock_req: RTL
============================

// Module: axi_llc_arcane_lock_req
// PURPOSE
//   eCPU-side initiator of the ARCANE LLC lock handshake. Turns software lock/unlock writes into the
//   ecpu_lock / ecpu_lock_req pair consumed by the LLC arcane lock FSM and completes on ready_lock.
//   Sits between the ARCANE control register file and the LLC control path. Filters redundant writes:
//   no request is issued when the written value equals the current lock state.
// PARAMETERS
//   TIMEOUT_CYCLES  1024  cycles a request may wait for ready_lock_i before timeout_o sets (>=2)
//   localparam CNT_W = $clog2(TIMEOUT_CYCLES+1)
// PORTS
//   clk_i            in   1  clock
//   rst_ni           in   1  asynchronous reset, active low
//   sw_we_i          in   1  software write strobe to lock control bit
//   sw_wdata_i       in   1  1 = acquire lock, 0 = release lock
//   sw_busy_o        out  1  handshake in flight (ACQ/REL)
//   sw_drop_o        out  1  1-cycle pulse: write ignored because busy
//   done_o           out  1  1-cycle pulse: acquire or release completed
//   ecpu_lock_o      out  1  current lock state (register), to LLC FSM and SW readback
//   ecpu_lock_req_o  out  1  lock/unlock request level to LLC FSM
//   ready_lock_i     in   1  grant from LLC FSM (Mealy on its side; sample only, never combinational loop)
//   err_clr_i        in   1  clears sticky timeout_o
//   timeout_o        out  1  sticky: request waited >= TIMEOUT_CYCLES
// BEHAVIOUR
//   States: UNLOCKED, ACQ, LOCKED, REL. Reset: UNLOCKED; all outputs 0, counter 0.
//   ecpu_lock_o = 1 in LOCKED and REL; 0 in UNLOCKED and ACQ (registered, glitch-free).
//   ecpu_lock_req_o = 1 exactly in ACQ and REL (decoded from registered state).
//   sw_busy_o = (state==ACQ || state==REL).
//   UNLOCKED: sw_we_i & sw_wdata_i -> ACQ next cycle; sw_we_i & ~sw_wdata_i -> no-op, stay, no pulse.
//   LOCKED:   sw_we_i & ~sw_wdata_i -> REL; sw_we_i & sw_wdata_i -> no-op, stay.
//   ACQ: ready_lock_i=1 at edge -> LOCKED (lock=1, req=0 same edge), done_o=1 next cycle.
//   REL: ready_lock_i=1 at edge -> UNLOCKED (lock=0, req=0 same edge), done_o=1 next cycle.
//   Min latency write->done_o: 3 cycles (write edge, grant edge, done cycle) when ready_lock_i already 1.
//   ACQ/REL: sw_we_i (any data) ignored, sw_drop_o pulses the following cycle; request not aborted
//     (LLC FSM cannot back out of isolation mid-handshake).
//   ready_lock_i in UNLOCKED/LOCKED ignored (LLC FSM drives it high in its LOCK state).
//   Simultaneous sw_we_i and grant in ACQ/REL: grant wins, write dropped with sw_drop_o.
//   err_clr_i and timeout set in same cycle: set wins.
//   Reset mid-operation: returns to UNLOCKED, req/lock deassert asynchronously; LLC FSM is reset
//     on the same rst_ni, no recovery sequence required.
// CONFIGURATION
//   AXI_LLC_ARCANE_LOCK_TIMEOUT_EN defined: CNT_W counter clears on ACQ/REL entry, increments each cycle
//     in ACQ/REL, saturates at TIMEOUT_CYCLES; reaching TIMEOUT_CYCLES sets timeout_o (sticky). The
//     handshake keeps waiting; timeout is report-only. Cleared only by err_clr_i or reset.
//   Not defined: no counter instantiated, timeout_o tied 0, err_clr_i unused.
// TESTING
//   Acquire, ready_lock_i held 1: sw_we=1,wdata=1 @c0 -> req=1 c1, lock=1 req=0 c2, done_o=1 c2 only.
//   Acquire with ready delayed 10 cycles -> req held 10 cycles, lock rises on grant edge, done 1 pulse.
//   Release from LOCKED: wdata=0 -> REL, req=1 with lock=1 until grant, then lock=0 req=0, done_o pulse.
//   Redundant writes: wdata=1 in LOCKED, wdata=0 in UNLOCKED -> no req, no done_o, no sw_drop_o.
//   Write during ACQ (wdata=0) -> sw_drop_o 1 pulse, acquire still completes to LOCKED.
//   TIMEOUT_EN, TIMEOUT_CYCLES=8, no grant -> timeout_o=1 after 8 cycles in ACQ, req stays 1;
//     err_clr_i -> timeout_o=0; async rst_ni mid-ACQ -> req=0, lock=0 immediately.

Source files
------------

// File: rtl/axi_llc_arcane_lock_req.sv
// eCPU-side initiator of the ARCANE LLC lock handshake: software lock writes become ecpu_lock/req.
// Optional request watchdog enabled by defining AXI_LLC_ARCANE_LOCK_TIMEOUT_EN.
module axi_llc_arcane_lock_req #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_we_i,
  input  logic sw_wdata_i,
  output logic sw_busy_o,
  output logic sw_drop_o,
  output logic done_o,
  output logic ecpu_lock_o,
  output logic ecpu_lock_req_o,
  input  logic ready_lock_i,
  input  logic err_clr_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StUnlocked,
    StAcq,
    StLocked,
    StRel
  } state_e;

  state_e state_q, state_d;
  logic   lock_q, lock_d;
  logic   done_q, done_d;
  logic   drop_q, drop_d;
  logic   busy, busy_next;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      StUnlocked: begin
        // Releasing an unheld lock is a silent no-op.
        if (sw_we_i && sw_wdata_i) state_d = StAcq;
      end
      StLocked: begin
        if (sw_we_i && !sw_wdata_i) state_d = StRel;
      end
      StAcq: begin
        // The LLC cannot back out mid-handshake, so writes here are dropped, not aborts.
        drop_d = sw_we_i;
        if (ready_lock_i) begin
          state_d = StLocked;
          done_d  = 1'b1;
        end
      end
      StRel: begin
        drop_d = sw_we_i;
        if (ready_lock_i) begin
          state_d = StUnlocked;
          done_d  = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_comb begin
    busy      = (state_q == StAcq) || (state_q == StRel);
    busy_next = (state_d == StAcq) || (state_d == StRel);
    lock_d    = (state_d == StLocked) || (state_d == StRel);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StUnlocked;
      lock_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign ecpu_lock_o     = lock_q;
  assign ecpu_lock_req_o = busy;
  assign sw_busy_o       = busy;
  assign done_o          = done_q;
  assign sw_drop_o       = drop_q;

`ifdef AXI_LLC_ARCANE_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (busy_next && !busy) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (err_clr_i) timeout_d = 1'b0;
    // Set only on the reaching edge so a clear sticks while the request keeps waiting.
    if (busy && (cnt_q != CntMax) && (cnt_d == CntMax)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign timeout_o      = 1'b0;
`endif

endmodule
